// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and default sizes for the UART TX arbiter
package uart_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int N_REQ_DEFAULT   = 4;
    localparam int DATA_W_DEFAULT  = 8;
    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner search
// Ports:
//   req_i        : request vector, one bit per requester
//   last_owner_i : index of the previous owner; search starts one above it
//   winner_o     : index of the first requesting bit found (0 when none)
//   found_o      : 1 when any request bit is set
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_owner_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             found_o
);

    logic [IDX_W-1:0] idx_v;

    // Walk offsets from farthest to nearest so the nearest requester
    // above last_owner overwrites any earlier match and wins.
    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        idx_v    = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            idx_v = IDX_W'((int'(last_owner_i) + off) % N_REQ);
            if (req_i[idx_v]) begin
                winner_o = idx_v;
                found_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin message arbiter feeding a UART TX FIFO
// Optional feature macro: UART_ARB_TIMEOUT_EN (stall timeout with forced release)
// Ports:
//   clk, reset       : clock and asynchronous active-high reset
//   req_valid/data/last, req_ready : per-requester byte stream, data packed
//                      as requester i at [i*DATA_W +: DATA_W]
//   tx_fifo_Full     : FIFO full, stalls the current owner
//   tx_fifo_writeEn, tx_fifo_dataIn : FIFO write strobe and byte
//   grant_id, busy   : current owner, message in progress
//   timeout_err      : one-cycle pulse on forced release
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      tx_fifo_Full,
    output logic                      tx_fifo_writeEn,
    output logic [DATA_W-1:0]         tx_fifo_dataIn,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_owner_q, last_owner_d;
    logic [IDX_W-1:0] winner;
    logic             found;
    logic             xfer;
    logic             timeout_fire;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req_i        (req_valid),
        .last_owner_i (last_owner_q),
        .winner_o     (winner),
        .found_o      (found)
    );

    // A byte moves only while granted, the owner is valid and the FIFO has room.
    assign xfer = (state_q == GRANT) && req_valid[grant_q] && !tx_fifo_Full;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout_err_q;
    logic             stall;

    // Owner idle while the FIFO could accept: this is the only stall we time.
    assign stall = (state_q == GRANT) && !req_valid[grant_q] && !tx_fifo_Full;

    always_comb begin
        stall_cnt_d  = '0;
        timeout_fire = 1'b0;
        if (stall) begin
            if (stall_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                timeout_fire = 1'b1;
            end else begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            timeout_err_q <= timeout_fire;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_fire = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_owner_q <= IDX_W'(N_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    grant_d = winner;
                end
            end
            GRANT: begin
                if ((xfer && req_last[grant_q]) || timeout_fire) begin
                    state_d      = IDLE;
                    last_owner_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready       = '0;
        tx_fifo_writeEn = 1'b0;
        tx_fifo_dataIn  = '0;
        busy            = (state_q == GRANT);
        if (state_q == GRANT) begin
            req_ready[grant_q] = !tx_fifo_Full;
        end
        if (xfer) begin
            tx_fifo_writeEn = 1'b1;
            tx_fifo_dataIn  = req_data[int'(grant_q) * DATA_W +: DATA_W];
        end
    end

    assign grant_id = grant_q;

endmodule
